input_debounce_2: RTL and testbench
===================================

# input_debounce_2

Two-channel synchronizing debouncer that sits directly upstream of the 2-input AND gate stage. It takes two raw, asynchronous, possibly bouncing inputs, synchronizes each into the clock domain, and filters out glitches. Its clean outputs `A` and `B` drive the gate's `A`/`B` inputs directly. It also emits one-cycle rise/fall pulses per channel for downstream event logic.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive cycles a synchronized input must differ from the current output before the output follows it. Legal range 1..255.

Ports:
- `CLK` input 1: single clock; all state updates on rising edge.
- `RST` input 1: reset, synchronous, active-high.
- `A_raw` input 1: raw asynchronous channel A.
- `B_raw` input 1: raw asynchronous channel B.
- `A` output 1: debounced channel A, registered; feeds the AND stage `A`.
- `B` output 1: debounced channel B, registered; feeds the AND stage `B`.
- `A_rise` output 1: one-cycle pulse, high in the cycle `A` becomes 1.
- `A_fall` output 1: one-cycle pulse, high in the cycle `A` becomes 0.
- `B_rise` output 1: one-cycle pulse for `B` 0->1.
- `B_fall` output 1: one-cycle pulse for `B` 1->0.

## Operation
- The two channels are identical and fully independent. No shared state exists between them.
- Each channel contains:
  - A 2-flop synchronizer: `s1 <= raw`, `s2 <= s1`.
  - A stability counter `cnt` of width ceil(log2(STABLE_CYCLES+1)).
  - An output register `out`, which is `A` or `B`.
- Per rising edge, using pre-edge values:
  - `RST`=1: `s1`, `s2`, `cnt`, `out`, and all pulse outputs go to 0. `RST` overrides everything else.
  - `s2 == out`: `cnt <= 0`, `out` holds.
  - `s2 != out` and `cnt == STABLE_CYCLES-1`:
    - `out <= s2` and `cnt <= 0`.
    - The matching pulse (`*_rise` if `s2`=1, else `*_fall`) is 1 for the next cycle.
  - `s2 != out` otherwise: `cnt <= cnt+1`, `out` holds.
- Pulse outputs are registered. Each is 1 for exactly one cycle, coincident with the first cycle of the new `out` value, and 0 otherwise.
- Any return of `s2` to `out` before the count completes discards progress: `cnt` goes back to 0, with no partial credit.
- `cnt` never exceeds STABLE_CYCLES-1, so no wrap-around is possible.

## Timing
- Reset values: `A`=`B`=0; `A_rise`=`A_fall`=`B_rise`=`B_fall`=0; internal `s1`, `s2`, `cnt` = 0.
- Latency: if `raw` changes before edge 0 and stays stable, `s2` shows it after edge 1, and `out` changes at edge STABLE_CYCLES+1.
  - For the default of 4, `out` changes at edge 5, and the pulse is high from edge 5 to edge 6.
- Glitch rejection: any excursion of `s2` lasting fewer than STABLE_CYCLES cycles produces no output change and no pulse.
- Both channels changing in the same cycle update on the same edge; both pulses may be high together.
- Raw held high through reset:
  - The output rises at edge STABLE_CYCLES+2 after the last edge with `RST`=1, because the synchronizer restarts from 0.
  - `*_rise` pulses at that point.
- Reset asserted mid-count: the count is lost. The edge after `RST` deasserts restarts synchronization from zero, and no pulse is emitted during or because of reset.
- `STABLE_CYCLES`=1: the output follows `s2` one edge after `s2` differs. This is a pure 3-cycle delay chain with no filtering.

## Test plan
All scenarios use `STABLE_CYCLES`=4 unless noted.

1. Reset: hold `RST`=1 for 3 cycles with `A_raw`=`B_raw`=1 -> all outputs 0 during reset. After release, `A`=`B`=1 at edge 6, with `A_rise`=`B_rise`=1 for exactly that cycle.
2. Clean step: `A_raw` 0->1 before edge 0 and held -> `A` stays 0 through edge 4 and becomes 1 at edge 5. `A_rise` is 1 for one cycle. `B` and its pulses stay 0 throughout.
3. Glitch rejection: `A_raw` high for 3 cycles then low, with `A`=0 -> `A` never changes, and `A_rise`/`A_fall` never assert. Repeat with a 4-cycle pulse -> `A` rises, then falls 5 edges after the drop, each with one pulse.
4. Bounce: `A_raw` toggles 1,0,1,0,1 on consecutive cycles, then holds 1 -> exactly one `A_rise`, 5 edges after the final transition; no `A_fall`.
5. Simultaneous: `A_raw` 0->1 and `B_raw` 1->0 in the same cycle, starting from debounced `A`=0, `B`=1 -> `A` and `B` update on the same edge, with `A_rise` and `B_fall` both high for that one cycle.
6. Reset mid-count: begin a step on `A_raw`, assert `RST` for 1 cycle at edge 3 -> `A` stays 0, no pulse. After release, `A` rises 6 edges after the reset edge. Also check that the AND stage output driven from `A` and `B` matches `A & B` after each settle.

Source files
------------

// File: rtl/input_debounce_2_if.sv
// ---------------------------------------------------------------------------
// input_debounce_2_if
// Signal bundle between the raw two-channel source and the debouncer.
//   A_raw, B_raw   : raw asynchronous, possibly bouncing channel inputs
//   A, B           : debounced, registered channel outputs (feed AND stage)
//   A_rise, A_fall : one-cycle edge pulses for channel A
//   B_rise, B_fall : one-cycle edge pulses for channel B
// The master modport is the side that drives the raw inputs and consumes the
// clean outputs; the slave modport is the debouncer itself.
// ---------------------------------------------------------------------------
interface input_debounce_2_if;

   logic A_raw;
   logic B_raw;
   logic A;
   logic B;
   logic A_rise;
   logic A_fall;
   logic B_rise;
   logic B_fall;

   modport master (
      output A_raw,
      output B_raw,
      input  A,
      input  B,
      input  A_rise,
      input  A_fall,
      input  B_rise,
      input  B_fall
   );

   modport slave (
      input  A_raw,
      input  B_raw,
      output A,
      output B,
      output A_rise,
      output A_fall,
      output B_rise,
      output B_fall
   );

endinterface

// File: rtl/input_debounce_2.sv
// ---------------------------------------------------------------------------
// input_debounce_2
// Two independent synchronizing debouncers feeding a 2-input AND stage.
// Each channel: 2-flop synchronizer, stability counter, output register and
// registered rise/fall pulses.
//   Parameter STABLE_CYCLES (1..255): consecutive cycles the synchronized
//   input must differ from the output before the output follows it.
//   CLK : clock, rising-edge
//   RST : synchronous active-high reset
//   bus : input_debounce_2_if.slave (raw inputs in, clean outputs out)
// ---------------------------------------------------------------------------
module input_debounce_2 #(
   parameter int STABLE_CYCLES = 4
) (
   input logic               CLK,
   input logic               RST,
   input_debounce_2_if.slave bus
);

   localparam int CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   // Channel index 0 is A, index 1 is B.
   logic [1:0]         raw;
   logic [1:0]         s1;
   logic [1:0]         s2;
   logic [1:0]         out;
   logic [1:0]         rise;
   logic [1:0]         fall;
   logic [1:0][CW-1:0] cnt;

   assign raw = {bus.B_raw, bus.A_raw};

   // Synchronizer plus per-channel filter. The counter only advances while the
   // synchronized value disagrees with the output; any agreement wipes it, so
   // the output moves only after an unbroken run of STABLE_CYCLES disagreements.
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1   <= '0;
         s2   <= '0;
         out  <= '0;
         rise <= '0;
         fall <= '0;
         cnt  <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         for (int ch = 0; ch < 2; ch++) begin
            rise[ch] <= 1'b0;
            fall[ch] <= 1'b0;
            if (s2[ch] == out[ch]) begin
               cnt[ch] <= '0;
            end else if (cnt[ch] == CNT_LAST) begin
               // Pulse is registered alongside out so it lines up with the
               // first cycle of the new output value.
               out[ch]  <= s2[ch];
               cnt[ch]  <= '0;
               rise[ch] <= s2[ch];
               fall[ch] <= ~s2[ch];
            end else begin
               cnt[ch] <= cnt[ch] + 1'b1;
            end
         end
      end
   end

   assign bus.A      = out[0];
   assign bus.B      = out[1];
   assign bus.A_rise = rise[0];
   assign bus.A_fall = fall[0];
   assign bus.B_rise = rise[1];
   assign bus.B_fall = fall[1];

endmodule

// File: tb/tb_input_debounce_2.sv
// ---------------------------------------------------------------------------
// tb_input_debounce_2
// Randomized and directed stimulus for input_debounce_2 with a sample-window
// reference model: an output flips when the last STABLE_CYCLES synchronized
// samples taken since reset all disagree with it.
// ---------------------------------------------------------------------------
module tb_input_debounce_2;

   localparam int N = 4;

   logic CLK;
   logic RST;
   int   vectors;
   int   miscompares;

   input_debounce_2_if bus ();

   input_debounce_2 #(.STABLE_CYCLES(N)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   // Free-running clock, period 10.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Reference model state: synchronizer pipeline and a history of the
   // synchronized samples seen since the last reset, newest at index 0.
   bit mS1   [2];
   bit mS2   [2];
   bit mOut  [2];
   bit mRise [2];
   bit mFall [2];
   bit hist  [2][0:63];
   int histLen [2];
   bit modelValid = 1'b0;

   // Model advances on each rising edge using the pre-edge input values.
   always @(posedge CLK) begin
      bit rawNow [2];
      bit fires;
      rawNow[0] = bus.A_raw;
      rawNow[1] = bus.B_raw;
      if (RST) begin
         modelValid = 1'b1;
         for (int ch = 0; ch < 2; ch++) begin
            mS1[ch]     = 1'b0;
            mS2[ch]     = 1'b0;
            mOut[ch]    = 1'b0;
            mRise[ch]   = 1'b0;
            mFall[ch]   = 1'b0;
            histLen[ch] = 0;
         end
      end else begin
         for (int ch = 0; ch < 2; ch++) begin
            for (int i = 63; i > 0; i--) hist[ch][i] = hist[ch][i-1];
            hist[ch][0] = mS2[ch];
            if (histLen[ch] < 64) histLen[ch]++;
            fires = (histLen[ch] >= N);
            for (int i = 0; i < N; i++)
               if (hist[ch][i] == mOut[ch]) fires = 1'b0;
            mRise[ch] = 1'b0;
            mFall[ch] = 1'b0;
            if (fires) begin
               mOut[ch]  = ~mOut[ch];
               mRise[ch] = mOut[ch];
               mFall[ch] = ~mOut[ch];
            end
            mS2[ch] = mS1[ch];
            mS1[ch] = rawNow[ch];
         end
      end
   end

   task automatic checkOutput(input string name, input logic actual, input logic expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
      end
   endtask

   // Every-cycle comparison of the DUT against the model, away from the edge.
   always @(negedge CLK) begin
      if (modelValid) begin
         checkOutput("model_A",      bus.A,         mOut[0]);
         checkOutput("model_B",      bus.B,         mOut[1]);
         checkOutput("model_A_rise", bus.A_rise,    mRise[0]);
         checkOutput("model_A_fall", bus.A_fall,    mFall[0]);
         checkOutput("model_B_rise", bus.B_rise,    mRise[1]);
         checkOutput("model_B_fall", bus.B_fall,    mFall[1]);
         checkOutput("model_AND",    bus.A & bus.B, mOut[0] & mOut[1]);
      end
   end

   // Drive inputs for one edge, then return shortly after that edge.
   task automatic applyStimulus(input bit a, input bit b, input bit r);
      bus.A_raw = a;
      bus.B_raw = b;
      RST       = r;
      @(posedge CLK);
      #2;
   endtask

   task automatic settle(input bit a, input bit b);
      for (int i = 0; i < 10; i++) applyStimulus(a, b, 1'b0);
   endtask

   initial begin
      int riseCnt;
      int fallCnt;
      int runA;
      int runB;
      bit valA;
      bit valB;
      vectors     = 0;
      miscompares = 0;
      bus.A_raw   = 1'b1;
      bus.B_raw   = 1'b1;
      RST         = 1'b1;
      #1;

      // Reset with both raw inputs high; outputs rise 6 edges after release.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b1);
         checkOutput("rst_A",      bus.A,      1'b0);
         checkOutput("rst_B",      bus.B,      1'b0);
         checkOutput("rst_A_rise", bus.A_rise, 1'b0);
      end
      for (int k = 1; k <= 7; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         checkOutput("rel_A",      bus.A,      (k >= 6));
         checkOutput("rel_B",      bus.B,      (k >= 6));
         checkOutput("rel_A_rise", bus.A_rise, (k == 6));
         checkOutput("rel_B_rise", bus.B_rise, (k == 6));
      end

      // Clean step on A.
      settle(1'b0, 1'b0);
      for (int k = 0; k <= 6; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         checkOutput("step_A",      bus.A,      (k >= 5));
         checkOutput("step_A_rise", bus.A_rise, (k == 5));
         checkOutput("step_B",      bus.B,      1'b0);
      end

      // Three-cycle glitch is rejected.
      settle(1'b0, 1'b0);
      riseCnt = 0;
      fallCnt = 0;
      for (int k = 0; k < 14; k++) begin
         applyStimulus((k < 3), 1'b0, 1'b0);
         riseCnt += int'(bus.A_rise);
         fallCnt += int'(bus.A_fall);
         checkOutput("glitch3_A", bus.A, 1'b0);
      end
      checkOutput("glitch3_pulses", (riseCnt + fallCnt) != 0, 1'b0);

      // Four-cycle pulse passes: rise at edge 5, fall at edge 9.
      riseCnt = 0;
      fallCnt = 0;
      for (int k = 0; k < 14; k++) begin
         applyStimulus((k < 4), 1'b0, 1'b0);
         riseCnt += int'(bus.A_rise);
         fallCnt += int'(bus.A_fall);
         if (k == 5) checkOutput("pulse4_rise", bus.A_rise, 1'b1);
         if (k == 9) checkOutput("pulse4_fall", bus.A_fall, 1'b1);
      end
      checkOutput("pulse4_one_rise", riseCnt == 1, 1'b1);
      checkOutput("pulse4_one_fall", fallCnt == 1, 1'b1);

      // Bounce 1,0,1,0,1 then hold: single rise at edge 9.
      settle(1'b0, 1'b0);
      riseCnt = 0;
      fallCnt = 0;
      for (int k = 0; k < 14; k++) begin
         applyStimulus((k >= 4) || (k % 2 == 0), 1'b0, 1'b0);
         riseCnt += int'(bus.A_rise);
         fallCnt += int'(bus.A_fall);
         if (k == 9) checkOutput("bounce_rise_at9", bus.A_rise, 1'b1);
      end
      checkOutput("bounce_one_rise", riseCnt == 1, 1'b1);
      checkOutput("bounce_no_fall",  fallCnt == 0, 1'b1);

      // Simultaneous A 0->1 and B 1->0.
      settle(1'b0, 1'b1);
      for (int k = 0; k <= 6; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         checkOutput("simul_A",      bus.A,      (k >= 5));
         checkOutput("simul_B",      bus.B,      (k < 5));
         checkOutput("simul_A_rise", bus.A_rise, (k == 5));
         checkOutput("simul_B_fall", bus.B_fall, (k == 5));
      end

      // Reset at edge 3 of a step; A rises 6 edges after the reset edge.
      settle(1'b0, 1'b0);
      for (int k = 0; k <= 10; k++) begin
         applyStimulus(1'b1, 1'b0, (k == 3));
         checkOutput("midrst_A",      bus.A,      (k >= 9));
         checkOutput("midrst_A_rise", bus.A_rise, (k == 9));
      end

      // Randomized run lengths per channel with occasional resets.
      settle(1'b1, 1'b1);
      valA = 1'b0;
      valB = 1'b0;
      runA = 0;
      runB = 0;
      for (int c = 0; c < 3000; c++) begin
         if (runA == 0) begin
            valA = ~valA;
            runA = int'($urandom_range(1, 8));
         end
         if (runB == 0) begin
            valB = ~valB;
            runB = int'($urandom_range(1, 8));
         end
         runA--;
         runB--;
         applyStimulus(valA, valB, ($urandom_range(0, 199) == 0));
      end

      applyStimulus(1'b0, 1'b0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
